// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types for the response demux:
// channel tags, default payload width and the per-channel slot state.
package cpu_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NCH            = 4;

  localparam logic [1:0] CH_IF    = 2'd0;
  localparam logic [1:0] CH_LSU   = 2'd1;
  localparam logic [1:0] CH_DBG   = 2'd2;
  localparam logic [1:0] CH_SPARE = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot write strobe for the tagged channel, all zero when not enabled.
  function automatic logic [NCH-1:0] sel_onehot(input logic [1:0] sel, input logic en);
    logic [NCH-1:0] v;
    v = '0;
    if (en) begin
      v[sel] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/resp_demux_1to4_if.sv
// Bundle of the upstream beat port and the four consumer channel ports.
interface resp_demux_1to4_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_sel;
  logic [DATA_W-1:0]     in_data;
  logic [NCH-1:0]        out_valid;
  logic [NCH-1:0]        out_ready;
  logic [NCH*DATA_W-1:0] out_data;
  logic                  busy;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_sel,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

  modport master (
    output flush,
    output in_valid,
    output in_sel,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

endinterface

// File: rtl/resp_slot.sv
// One-entry registered output slot with valid/ready handshake; a write in the
// same cycle as a drain refills the slot so a channel can stream every cycle.
module resp_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  slot_state_e       r_state;
  slot_state_e       w_nextState;
  logic [DATA_W-1:0] r_data;
  logic              w_load;
  logic              w_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_data <= wr_data;
      end
    end
  end

  // Flush wins over everything; a write wins over a drain so the slot refills.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_drain     = (r_state == SLOT_FULL) && ready;
    if (flush) begin
      w_nextState = SLOT_EMPTY;
    end else if (wr_en) begin
      w_nextState = SLOT_FULL;
      w_load      = 1'b1;
    end else if (w_drain) begin
      w_nextState = SLOT_EMPTY;
    end
  end

  assign valid = (r_state == SLOT_FULL);
  assign data  = r_data;

endmodule

// File: rtl/resp_demux_1to4.sv
// Routes one response stream to four independently back-pressured consumer
// channels (IF, LSU, DBG, SPARE) selected by a 2-bit tag.
module resp_demux_1to4
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  resp_demux_1to4_if.slave   bus
);

  logic              w_inReady;
  logic              w_accept;
  logic [NCH-1:0]    w_wrEn;
  logic [NCH-1:0]    w_slotValid;
  logic [DATA_W-1:0] w_slotData [NCH];

  // Only the addressed channel's occupancy gates acceptance, so a stalled
  // consumer never blocks beats headed elsewhere.
  assign w_inReady = !bus.flush &&
                     (!w_slotValid[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign w_accept  = bus.in_valid && w_inReady;
  assign w_wrEn    = sel_onehot(bus.in_sel, w_accept);

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    resp_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (bus.flush),
      .wr_en   (w_wrEn[k]),
      .wr_data (bus.in_data),
      .valid   (w_slotValid[k]),
      .ready   (bus.out_ready[k]),
      .data    (w_slotData[k])
    );

    assign bus.out_data[k*DATA_W +: DATA_W] = w_slotData[k];
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_slotValid;
  assign bus.busy      = |w_slotValid;

endmodule

// File: tb/tb_resp_demux_1to4.sv
// Directed bench for resp_demux_1to4: per-channel occupancy model checked
// every cycle, plus literal expectations for the key routing scenarios.
module tb_resp_demux_1to4;

  localparam int DW = 32;

  logic clk;
  logic rst_n;

  resp_demux_1to4_if #(.DATA_W(DW)) bus ();

  resp_demux_1to4 #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit cmpEn       = 1'b0;

  logic [3:0]    mValid;
  logic [DW-1:0] mData [4];
  logic          expReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [DW-1:0] d, input logic [3:0] rdy,
                               input logic fl);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel occupancy model: a slot is occupied until drained or flushed,
  // and the accepted beat lands in the tagged slot.
  assign expReady = !bus.flush && (!mValid[bus.in_sel] || bus.out_ready[bus.in_sel]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid <= 4'b0000;
      for (int k = 0; k < 4; k++) mData[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.flush || (mValid[k] && bus.out_ready[k])) mValid[k] <= 1'b0;
      end
      if (bus.in_valid && expReady) begin
        mValid[bus.in_sel] <= 1'b1;
        mData[bus.in_sel]  <= bus.in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
      checkOutput("busy", 32'(bus.busy), 32'(|mValid));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
      for (int k = 0; k < 4; k++) begin
        if (mValid[k]) begin
          checkOutput($sformatf("out_data%0d", k), bus.out_data[k*DW +: DW], mData[k]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(|bus.out_data), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
    cmpEn = 1'b1;
    tick();
    rst_n = 1'b1;

    $display("[TB] reset then route");
    applyStimulus(1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd1, '0, 4'b0000, 1'b0);
    checkOutput("route_valid", 32'(bus.out_valid), 32'h2);
    checkOutput("route_data1", bus.out_data[1*DW +: DW], 32'hDEADBEEF);
    checkOutput("ready_sel1", 32'(bus.in_ready), 32'h0);
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checkOutput("ready_sel0", 32'(bus.in_ready), 32'h1);

    $display("[TB] backpressure isolation");
    applyStimulus(1'b1, 2'd2, 32'h12345678, 4'b0000, 1'b0);
    checkOutput("iso_accept", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checkOutput("iso_valid", 32'(bus.out_valid), 32'h6);
    checkOutput("iso_data1", bus.out_data[1*DW +: DW], 32'hDEADBEEF);
    checkOutput("iso_data2", bus.out_data[2*DW +: DW], 32'h12345678);

    $display("[TB] streaming ch0");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'd0, DW'(i), 4'b0001, 1'b0);
      checkOutput("stream_ready", 32'(bus.in_ready), 32'h1);
      tick();
      checkOutput("stream_valid0", 32'(bus.out_valid[0]), 32'h1);
      checkOutput("stream_data0", bus.out_data[0 +: DW], 32'(i));
    end
    applyStimulus(1'b0, 2'd0, '0, 4'b0001, 1'b0);
    tick();

    $display("[TB] drain and write same cycle");
    applyStimulus(1'b1, 2'd3, 32'hA, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd3, 32'hB, 4'b1000, 1'b0);
    checkOutput("dw_ready", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checkOutput("dw_valid3", 32'(bus.out_valid[3]), 32'h1);
    checkOutput("dw_data3", bus.out_data[3*DW +: DW], 32'hB);

    $display("[TB] flush");
    applyStimulus(1'b1, 2'd0, 32'h55, 4'b0000, 1'b0);
    tick();
    checkOutput("pre_flush_valid", 32'(bus.out_valid), 32'hF);
    applyStimulus(1'b1, 2'd0, 32'hFFFF, 4'b0000, 1'b1);
    checkOutput("flush_ready", 32'(bus.in_ready), 32'h0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checkOutput("flush_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("flush_busy", 32'(bus.busy), 32'h0);
    checkOutput("flush_nowrite", bus.out_data[0 +: DW], 32'h55);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 2'd1, 32'h111, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 32'h222, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("arst_busy", 32'(bus.busy), 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd2, 32'hCAFE, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'h4);
    checkOutput("post_rst_data2", bus.out_data[2*DW +: DW], 32'hCAFE);

    $display("[TB] mixed traffic");
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i % 3) != 2, 2'(i ^ (i >> 2)), 32'h100 + DW'(i),
                    4'(i * 5), (i == 11));
      tick();
    end
    applyStimulus(1'b0, 2'd0, '0, 4'b1111, 1'b0);
    repeat (2) tick();

    @(negedge clk);
    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
